if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the program counter, the instruction memory and the IF/ID pipeline register. Consumes the taken-branch redirect and flush from the EX-stage branch decision, the jump redirect from ID, the load-use stall from the hazard unit, and the run enable from the debug unit. Detects the HALT word and freezes fetch.

## Interface
- NB_PC, 32, PC and PC+4 width
- NB_INSTR, 32, instruction width
- NB_ADDR, 10, instruction-memory word-address width (depth 2^NB_ADDR)
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch
---
- i_clk  in  1  single clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  leave IDLE and begin fetching at PC 0
- i_enable  in  1  debug-unit advance enable (continuous run or single-step pulse)
- i_stall  in  1  hazard-unit load-use stall
- i_pc_src  in  1  taken branch from EX; load i_branch_target
- i_flush  in  1  taken branch from EX; kill IF/ID contents
- i_branch_target  in  NB_PC  branch target address
- i_jump  in  1  jump decoded in ID
- i_jump_target  in  NB_PC  jump target address
- i_imem_wr_en  in  1  debug-unit program-load write strobe
- i_imem_wr_addr  in  NB_ADDR  word address of program-load write
- i_imem_wr_data  in  NB_INSTR  program-load word
- o_pc  out  NB_PC  current PC (fetch address)
- o_instr  out  NB_INSTR  IF/ID instruction
- o_pc_plus4  out  NB_PC  IF/ID PC+4 of that instruction
- o_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- o_halt  out  1  fetch frozen on HALT_WORD
- o_state  out  2  FSM state for the debug unit (IDLE=0, RUN=1, HALTED=2)

## Operation
- FSM IDLE -> RUN on i_start; RUN -> HALTED when HALT_WORD is latched into IF/ID; HALTED -> RUN on i_pc_src; any state -> IDLE only on reset.
- IDLE: PC = 0, IF/ID = bubble (instr 0, pc_plus4 0, valid 0). Program-load writes are accepted only in IDLE and ignored in any other state.
- RUN with i_enable=0: PC and IF/ID hold. All other inputs are ignored.
- RUN with i_enable=1, priority highest first:
  1. i_pc_src: PC <= i_branch_target. Overrides stall and jump.
  2. i_jump: PC <= i_jump_target; IF/ID <= bubble. Overrides stall.
  3. i_stall: PC and IF/ID hold.
  4. Otherwise: PC <= PC+4; IF/ID <= {mem[PC], PC+4, valid=1}.
- i_flush (enabled cycle): IF/ID <= bubble, independent of the PC rule above.
- Halt: the fetched word equals HALT_WORD in a case-4 cycle. It is latched into IF/ID and PC holds at the HALT address, and the state moves to HALTED.
- HALTED, enabled cycle:
  - i_pc_src: a branch older than the halt is taken. State goes to RUN, PC is loaded with the target, IF/ID becomes a bubble.
  - i_stall alone: IF/ID holds.
  - Otherwise: IF/ID <= bubble and PC holds.
  - i_jump is ignored.
- Memory indexing uses PC[NB_ADDR+1:2]; upper PC bits are ignored, so addresses alias modulo depth. PC+4 wraps modulo 2^NB_PC. Low two PC bits are ignored for indexing.

## Timing
- Instruction memory read is combinational from PC. IF/ID is registered, so the word at PC appears on o_instr one enabled cycle after PC.
- Redirect latency: i_pc_src/i_jump asserted in cycle t gives the new PC in t+1 and the target instruction on o_instr in t+2.
- Program-load write takes effect at the next edge; a read of the same address in the same cycle returns old data.
- Reset (asynchronous, any time including mid-run or HALTED):
  - o_pc=0, o_instr=0, o_pc_plus4=0, o_valid=0, o_halt=0, o_state=IDLE.
  - Memory contents are not cleared.
- o_halt = (state == HALTED), registered.

## Structure
- Shared pipeline package: NB_PC, NB_INSTR, HALT_WORD, FSM state encodings, bubble constant (NOP = 32'h0).
- One sub-module, instr_mem: 2^NB_ADDR × NB_INSTR array with one synchronous write port and an asynchronous read port, no reset.
- PC register, FSM and IF/ID register live in if_stage.

## Test plan
- Load words 0x20010005, 0x20020007, 0xFFFFFFFF at addresses 0–2, then start. Required:
  - o_instr sequence 0x20010005, 0x20020007, 0xFFFFFFFF with o_pc_plus4 4, 8, 12.
  - o_halt=1 and o_pc frozen at 8.
- i_stall for 2 cycles at PC=4: o_pc stays 4 and o_instr/o_valid unchanged for 2 cycles, then resume at 8.
- i_pc_src=1, i_flush=1, i_stall=1, target 0x40, all in one cycle. Required: o_valid=0 next cycle, o_pc=0x40, and the instruction at word 16 appears the cycle after.
- i_jump with target 0x20 at PC=8: o_pc=0x20 next cycle with o_valid=0, then mem[8] on o_instr.
- In HALTED, i_pc_src with target 0x10: o_halt drops to 0, state returns to RUN, fetch resumes at 0x10.
- i_enable=0 for 3 cycles, program-load writes while in RUN, and reset asserted mid-run. Required:
  - no state change while i_enable=0;
  - RUN-state writes are ignored (memory readback unchanged);
  - after reset, all outputs are 0, state is IDLE, and the loaded program survives.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline constants for the fetch stage: datapath widths, HALT encoding,
// the bubble word and the fetch FSM state encodings.
package if_stage_pkg;

  localparam int unsigned NB_PC    = 32;
  localparam int unsigned NB_INSTR = 32;

  localparam logic [NB_INSTR-1:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [NB_INSTR-1:0] NOP       = 32'h0000_0000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_HALTED = 2'd2;

endpackage

// File: rtl/if_stage_instr_mem.sv
// Instruction memory: one synchronous write port for program load and an
// asynchronous read port for fetch. Contents are deliberately not reset.
module if_stage_instr_mem #(
  parameter int unsigned NB_ADDR  = 10,
  parameter int unsigned NB_INSTR = 32
) (
  input  logic                i_clk,
  input  logic                i_wr_en,
  input  logic [NB_ADDR-1:0]  i_wr_addr,
  input  logic [NB_INSTR-1:0] i_wr_data,
  input  logic [NB_ADDR-1:0]  i_rd_addr,
  output logic [NB_INSTR-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 1 << NB_ADDR;

  logic [NB_INSTR-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch FSM (IDLE/RUN/HALTED) and the
// IF/ID pipeline register, with branch/jump redirect, stall, flush and HALT.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned NB_ADDR = 10
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_enable,
  input  logic                i_stall,
  input  logic                i_pc_src,
  input  logic                i_flush,
  input  logic [NB_PC-1:0]    i_branch_target,
  input  logic                i_jump,
  input  logic [NB_PC-1:0]    i_jump_target,
  input  logic                i_imem_wr_en,
  input  logic [NB_ADDR-1:0]  i_imem_wr_addr,
  input  logic [NB_INSTR-1:0] i_imem_wr_data,
  output logic [NB_PC-1:0]    o_pc,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_PC-1:0]    o_pc_plus4,
  output logic                o_valid,
  output logic                o_halt,
  output logic [1:0]          o_state
);

  state_t              r_state, w_state_d;
  logic [NB_PC-1:0]    r_pc, w_pc_d, w_pc_plus4;
  logic [NB_INSTR-1:0] r_instr, w_instr_d, w_fetch;
  logic [NB_PC-1:0]    r_pc4, w_pc4_d;
  logic                r_valid, w_valid_d;
  logic                r_halt;
  logic                w_mem_wr_en;

  assign w_pc_plus4  = r_pc + NB_PC'(4);
  // Program load is only legal while the pipeline is parked in IDLE.
  assign w_mem_wr_en = i_imem_wr_en && (r_state == ST_IDLE);

  if_stage_instr_mem #(
    .NB_ADDR  (NB_ADDR),
    .NB_INSTR (NB_INSTR)
  ) u_instr_mem (
    .i_clk     (i_clk),
    .i_wr_en   (w_mem_wr_en),
    .i_wr_addr (i_imem_wr_addr),
    .i_wr_data (i_imem_wr_data),
    .i_rd_addr (r_pc[NB_ADDR+1:2]),
    .o_rd_data (w_fetch)
  );

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_instr_d = r_instr;
    w_pc4_d   = r_pc4;
    w_valid_d = r_valid;

    case (r_state)
      ST_IDLE: begin
        w_pc_d    = '0;
        w_instr_d = NOP;
        w_pc4_d   = '0;
        w_valid_d = 1'b0;
        if (i_start) begin
          w_state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (i_enable) begin
          if (i_pc_src) begin
            w_pc_d = i_branch_target;
          end else if (i_jump) begin
            w_pc_d    = i_jump_target;
            w_instr_d = NOP;
            w_pc4_d   = '0;
            w_valid_d = 1'b0;
          end else if (!i_stall) begin
            w_instr_d = w_fetch;
            w_pc4_d   = w_pc_plus4;
            w_valid_d = 1'b1;
            // HALT freezes PC at its own address; a flushed HALT is not a halt.
            if (w_fetch == HALT_WORD && !i_flush) begin
              w_state_d = ST_HALTED;
            end else begin
              w_pc_d = w_pc_plus4;
            end
          end
          if (i_flush) begin
            w_instr_d = NOP;
            w_pc4_d   = '0;
            w_valid_d = 1'b0;
          end
        end
      end

      ST_HALTED: begin
        if (i_enable) begin
          if (i_pc_src) begin
            w_state_d = ST_RUN;
            w_pc_d    = i_branch_target;
            w_instr_d = NOP;
            w_pc4_d   = '0;
            w_valid_d = 1'b0;
          end else if (!i_stall || i_flush) begin
            w_instr_d = NOP;
            w_pc4_d   = '0;
            w_valid_d = 1'b0;
          end
        end
      end

      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_instr <= NOP;
      r_pc4   <= '0;
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_instr <= w_instr_d;
      r_pc4   <= w_pc4_d;
      r_valid <= w_valid_d;
      r_halt  <= (w_state_d == ST_HALTED);
    end
  end

  assign o_pc       = r_pc;
  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc4;
  assign o_valid    = r_valid;
  assign o_halt     = r_halt;
  assign o_state    = r_state;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: per-cycle vector table with a scoreboard
// of expected IF outputs, plus hand sequences for reset and program load.
module tb_if_stage;
  import if_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halt;
    logic [1:0]  state;
  } out_t;

  typedef struct {
    logic        start, en, stall, pc_src, flush, jump, wr;
    logic [31:0] tgt;
    out_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0, i_enable = 1'b0, i_stall = 1'b0;
  logic        i_pc_src = 1'b0, i_flush = 1'b0, i_jump = 1'b0;
  logic [31:0] i_branch_target = '0, i_jump_target = '0;
  logic        i_imem_wr_en = 1'b0;
  logic [9:0]  i_imem_wr_addr = '0;
  logic [31:0] i_imem_wr_data = '0;
  logic [31:0] o_pc, o_instr, o_pc_plus4;
  logic        o_valid, o_halt;
  logic [1:0]  o_state;

  int   total = 0;
  int   bad = 0;
  out_t act;
  out_t sb[$];
  vec_t vecs[$];
  logic [31:0] mm [1024];

  always #5 clk = ~clk;

  if_stage #(.NB_ADDR(10)) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_enable        (i_enable),
    .i_stall         (i_stall),
    .i_pc_src        (i_pc_src),
    .i_flush         (i_flush),
    .i_branch_target (i_branch_target),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_imem_wr_en    (i_imem_wr_en),
    .i_imem_wr_addr  (i_imem_wr_addr),
    .i_imem_wr_data  (i_imem_wr_data),
    .o_pc            (o_pc),
    .o_instr         (o_instr),
    .o_pc_plus4      (o_pc_plus4),
    .o_valid         (o_valid),
    .o_halt          (o_halt),
    .o_state         (o_state)
  );

  assign act = {o_pc, o_instr, o_pc_plus4, o_valid, o_halt, o_state};

  function automatic out_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic v, input logic h,
                              input logic [1:0] st);
    return out_t'({pc, instr, pc4, v, h, st});
  endfunction

  function automatic out_t bub(input logic [31:0] pc, input logic h, input logic [1:0] st);
    return mk(pc, 32'h0, 32'h0, 1'b0, h, st);
  endfunction

  task automatic add(input logic start, input logic en, input logic stall, input logic pc_src,
                     input logic flush, input logic jump, input logic wr,
                     input logic [31:0] tgt, input out_t e);
    vec_t v;
    v.start = start; v.en = en; v.stall = stall; v.pc_src = pc_src;
    v.flush = flush; v.jump = jump; v.wr = wr; v.tgt = tgt; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input out_t e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got pc=%h instr=%h pc4=%h v=%b h=%b st=%0d, want pc=%h instr=%h pc4=%h v=%b h=%b st=%0d",
               name, act.pc, act.instr, act.pc4, act.valid, act.halt, act.state,
               e.pc, e.instr, e.pc4, e.valid, e.halt, e.state);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    out_t e;
    i_start = v.start; i_enable = v.en; i_stall = v.stall; i_pc_src = v.pc_src;
    i_flush = v.flush; i_jump = v.jump; i_branch_target = v.tgt; i_jump_target = v.tgt;
    i_imem_wr_en = v.wr; i_imem_wr_addr = 10'd16; i_imem_wr_data = 32'hDEAD_BEEF;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(name, e);
    i_start = 0; i_enable = 0; i_stall = 0; i_pc_src = 0; i_flush = 0; i_jump = 0;
    i_imem_wr_en = 0;
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("%s%0d", tag, i));
    vecs.delete();
  endtask

  initial begin
    mm[0] = 32'h2001_0005;
    mm[1] = 32'h2002_0007;
    mm[2] = 32'hFFFF_FFFF;
    for (int i = 3; i < 32; i++) mm[i] = 32'h1000_0000 + i;
    mm[1023] = 32'h0BAD_F00D;

    #2 i_reset = 1'b1;
    #2 check("reset", bub(0, 0, ST_IDLE));
    @(posedge clk); #1;
    i_reset = 1'b0;

    // Program load in IDLE
    for (int i = 0; i < 33; i++) begin
      i_imem_wr_en   = 1'b1;
      i_imem_wr_addr = (i == 32) ? 10'd1023 : 10'(i);
      i_imem_wr_data = (i == 32) ? mm[1023] : mm[i];
      @(posedge clk); #1;
    end
    i_imem_wr_en = 1'b0;
    check("idle_after_load", bub(0, 0, ST_IDLE));

    //  start en  stl src fls jmp wr  tgt
    add(1, 0, 0, 0, 0, 0, 0, 32'h0,  bub(0, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,  mk(32'h4, mm[0], 32'h4, 1, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,  mk(32'h8, mm[1], 32'h8, 1, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,  mk(32'h8, mm[2], 32'hC, 1, 1, ST_HALTED));
    add(0, 1, 0, 0, 0, 1, 0, 32'h30, bub(32'h8, 1, ST_HALTED));
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,  bub(32'h8, 1, ST_HALTED));
    add(0, 1, 0, 1, 0, 0, 0, 32'h10, bub(32'h10, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,  mk(32'h14, mm[4], 32'h14, 1, 0, ST_RUN));
    add(0, 1, 0, 1, 1, 0, 0, 32'h0,  bub(32'h0, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,  mk(32'h4, mm[0], 32'h4, 1, 0, ST_RUN));
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,  mk(32'h4, mm[0], 32'h4, 1, 0, ST_RUN));
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,  mk(32'h4, mm[0], 32'h4, 1, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,  mk(32'h8, mm[1], 32'h8, 1, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 1, 0, 32'h20, bub(32'h20, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,  mk(32'h24, mm[8], 32'h24, 1, 0, ST_RUN));
    add(0, 1, 1, 1, 1, 0, 0, 32'h40, bub(32'h40, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,  mk(32'h44, mm[16], 32'h44, 1, 0, ST_RUN));
    for (int i = 0; i < 3; i++)
      add(0, 0, 1, 1, 1, 1, 1, 32'h80, mk(32'h44, mm[16], 32'h44, 1, 0, ST_RUN));
    add(0, 1, 0, 1, 1, 0, 0, 32'h40, bub(32'h40, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,  mk(32'h44, mm[16], 32'h44, 1, 0, ST_RUN));
    add(0, 1, 0, 1, 1, 0, 0, 32'h1010, bub(32'h1010, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,  mk(32'h1014, mm[4], 32'h1014, 1, 0, ST_RUN));
    add(0, 1, 0, 1, 1, 0, 0, 32'hFFFF_FFFC, bub(32'hFFFF_FFFC, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,  mk(32'h0, mm[1023], 32'h0, 1, 0, ST_RUN));
    run_vecs("run");

    // Asynchronous reset mid-cycle while running
    #3 i_reset = 1'b1;
    #1 check("reset_mid", bub(0, 0, ST_IDLE));
    @(posedge clk); #1;
    check("reset_hold", bub(0, 0, ST_IDLE));
    i_reset = 1'b0;

    add(1, 0, 0, 0, 0, 0, 0, 32'h0, bub(0, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0, mk(32'h4, mm[0], 32'h4, 1, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0, mk(32'h8, mm[1], 32'h8, 1, 0, ST_RUN));
    add(0, 1, 0, 0, 0, 0, 0, 32'h0, mk(32'h8, mm[2], 32'hC, 1, 1, ST_HALTED));
    run_vecs("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
